// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: groups the TX FIFO pop side, the RX FIFO push side and the SPI pins.
// Latency: none, wires only.
// Backpressure: carries tx_empty / rx_full to the controller; the controller never strobes past them.
// Ports: master = controller view (drives strobes and pins), slave = FIFO/pad view.
interface spi_xfer_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] tx_dout;
    logic                 tx_empty;
    logic                 tx_re_en;
    logic [DATAWIDTH-1:0] rx_din;
    logic                 rx_full;
    logic                 rx_wr_en;
    logic                 sclk;
    logic                 mosi;
    logic                 miso;
    logic                 ss_n;

    modport master (
        input  tx_dout, tx_empty, rx_full, miso,
        output tx_re_en, rx_din, rx_wr_en, sclk, mosi, ss_n
    );

    modport slave (
        output tx_dout, tx_empty, rx_full, miso,
        input  tx_re_en, rx_din, rx_wr_en, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: master-side SPI byte sequencer between a TX FIFO and an RX FIFO, all four CPOL/CPHA modes.
// Latency: LOAD to rx_wr_en is 2 + 2*DATAWIDTH*(clk_div+1) cycles; SCLK half-period is clk_div+1 cycles.
// Backpressure: never pops an empty TX FIFO; holds in STORE with SCLK idle and SS_N low while RX is full.
// Ports: clk, rst (synchronous, active high); en, cpol, cpha, clk_div (config, latched at burst start);
//        busy, done (status); bus (spi_xfer_ctrl_if.master: TX pop, RX push, SCLK/MOSI/MISO/SS_N).
// Optional: define SPI_LSB_FIRST_EN to add input lsb_first (LSB-first framing, latched with the config).
module spi_xfer_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int DIVWIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIVWIDTH-1:0] clk_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    output logic                busy,
    output logic                done,
    spi_xfer_ctrl_if.master     bus
);

    localparam int EDGES = 2 * DATAWIDTH;
    localparam int ECW   = $clog2(EDGES + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(EDGES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SHIFT, ST_STORE, ST_NEXT, ST_END
    } state_t;

    state_t state_q, state_d;

    logic                 cpol_q, cpha_q, lsb_q;
    logic [DIVWIDTH-1:0]  div_q, div_cnt;
    logic [ECW-1:0]       edge_cnt;
    logic [DATAWIDTH-1:0] tx_sreg, rx_sreg, rx_din_q;
    logic                 sclk_q, mosi_q, done_q;
    logic                 div_tc, edge_fire, leading, sample_now, drive_now;
    logic                 lsb_cfg;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_cfg = lsb_first;
`else
    assign lsb_cfg = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATAWIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATAWIDTH-1];
    endfunction

    function automatic logic [DATAWIDTH-1:0] tx_shift(input logic [DATAWIDTH-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // LSB-first assembles from the top down so the first bit received ends up in bit 0.
    function automatic logic [DATAWIDTH-1:0] rx_shift(input logic [DATAWIDTH-1:0] d,
                                                      input logic lsb, input logic b);
        return lsb ? {b, d[DATAWIDTH-1:1]} : {d[DATAWIDTH-2:0], b};
    endfunction

    // edge_cnt counts SCLK edges already made in this byte; an even count means the
    // next edge is a leading one. Sampling happens on leading edges for cpha=0 and on
    // trailing edges for cpha=1; driving happens on the other edge type.
    assign div_tc     = (div_cnt == div_q);
    assign edge_fire  = (state_q == ST_SHIFT) && (edge_cnt != LAST_EDGE) && div_tc;
    assign leading    = ~edge_cnt[0];
    assign sample_now = edge_fire && (leading ^ cpha_q);
    assign drive_now  = edge_fire && !(leading ^ cpha_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.tx_re_en = 1'b0;
        bus.rx_wr_en = 1'b0;
        bus.ss_n     = 1'b0;
        busy         = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus.ss_n = 1'b1;
                busy     = 1'b0;
                if (en && !bus.tx_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bus.tx_re_en = !bus.tx_empty;
                state_d      = ST_SHIFT;
            end
            // One extra cycle after the last edge lets the final sample land in rx_din.
            ST_SHIFT: begin
                if (edge_cnt == LAST_EDGE) state_d = ST_STORE;
            end
            ST_STORE: begin
                if (!bus.rx_full) begin
                    bus.rx_wr_en = 1'b1;
                    state_d      = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = (en && !bus.tx_empty) ? ST_LOAD : ST_END;
            end
            ST_END: begin
                if (div_tc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset cycle must never move data in or out of either FIFO.
        if (rst) begin
            bus.tx_re_en = 1'b0;
            bus.rx_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sreg  <= '0;
            rx_sreg  <= '0;
            rx_din_q <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= cpol;
                    if (state_d == ST_LOAD) begin
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        div_q  <= clk_div;
                        lsb_q  <= lsb_cfg;
                    end
                end
                ST_LOAD: begin
                    sclk_q   <= cpol_q;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    // cpha=0 needs the first bit on MOSI before the first (sampling) edge;
                    // cpha=1 drives it on that first edge instead.
                    if (cpha_q) begin
                        tx_sreg <= bus.tx_dout;
                    end else begin
                        tx_sreg <= tx_shift(bus.tx_dout, lsb_q);
                        mosi_q  <= first_bit(bus.tx_dout, lsb_q);
                    end
                end
                ST_SHIFT: begin
                    if (edge_cnt == LAST_EDGE) begin
                        rx_din_q <= rx_sreg;
                    end else begin
                        div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
                        if (edge_fire) begin
                            sclk_q   <= ~sclk_q;
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                        if (sample_now) rx_sreg <= rx_shift(rx_sreg, lsb_q, bus.miso);
                        if (drive_now) begin
                            mosi_q  <= first_bit(tx_sreg, lsb_q);
                            tx_sreg <= tx_shift(tx_sreg, lsb_q);
                        end
                    end
                end
                ST_NEXT: begin
                    div_cnt <= '0;
                end
                ST_END: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_tc) done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sclk   = sclk_q;
    assign bus.mosi   = mosi_q;
    assign bus.rx_din = rx_din_q;
    assign done       = done_q;

endmodule
